// File: rtl/sound_arbiter.sv
`timescale 1ns/1ps
// sound_arbiter
//   Shares the single speaker pin among four sound sources (0 = ship death,
//   1 = alien hit, 2 = laser shot, 3 = menu click). One-cycle request
//   strobes are latched as pending. The highest-priority (lowest index)
//   pending source is granted. It then plays its square-wave tone for a
//   fixed number of duration ticks.
//
// Ports
//   clk        : system clock
//   reset      : asynchronous, active-high
//   req[3:0]   : one-cycle request strobes, bit 0 has the highest priority
//   enable     : 0 mutes the speaker; sequencing is unaffected
//   speaker    : registered square-wave tone
//   busy       : high while a source is playing
//   active_src : index of the playing source; holds its value when idle
//   grant[3:0] : one-hot pulse on the cycle a source starts or restarts
module sound_arbiter #(
  parameter int TICK_DIV = 250000,
  parameter int HALF0    = 50000,
  parameter int HALF1    = 25000,
  parameter int HALF2    = 12500,
  parameter int HALF3    = 6250,
  parameter int DUR0     = 50,
  parameter int DUR1     = 20,
  parameter int DUR2     = 8,
  parameter int DUR3     = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       enable,
  output logic       speaker,
  output logic       busy,
  output logic [1:0] active_src,
  output logic [3:0] grant
);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  pend;
  logic [15:0] half_cnt;
  logic [17:0] presc;
  logic [7:0]  dur_cnt;
  logic        tone;

  logic [1:0]  sel;
  logic [3:0]  sel_onehot;
  logic        any_pend;
  logic        tick_wrap;
  logic        load;
  logic        finish;

  function automatic logic [15:0] half_of(input logic [1:0] s);
    case (s)
      2'd0:    half_of = 16'(HALF0);
      2'd1:    half_of = 16'(HALF1);
      2'd2:    half_of = 16'(HALF2);
      default: half_of = 16'(HALF3);
    endcase
  endfunction

  function automatic logic [7:0] dur_of(input logic [1:0] s);
    case (s)
      2'd0:    dur_of = 8'(DUR0);
      2'd1:    dur_of = 8'(DUR1);
      2'd2:    dur_of = 8'(DUR2);
      default: dur_of = 8'(DUR3);
    endcase
  endfunction

  // Lowest set pending index wins; scanning downward lets it overwrite last.
  always_comb begin
    sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pend[i]) sel = 2'(i);
    end
  end

  assign sel_onehot = 4'b0001 << sel;
  assign any_pend   = |pend;
  assign tick_wrap  = (presc == 18'(TICK_DIV - 1));
  assign busy       = (state == PLAY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A pending request at or above the current priority preempts or
  // retriggers, and wins over end-of-play on the same edge.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (any_pend) begin
          load       = 1'b1;
          state_next = PLAY;
        end
      end
      PLAY: begin
        if (any_pend && (sel <= active_src)) begin
          load = 1'b1;
        end else if (tick_wrap && (dur_cnt == 8'd1)) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend       <= '0;
      half_cnt   <= '0;
      presc      <= '0;
      dur_cnt    <= '0;
      tone       <= 1'b0;
      speaker    <= 1'b0;
      grant      <= '0;
      active_src <= '0;
    end else begin
      grant   <= '0;
      speaker <= tone & enable;
      // A strobe landing on its own grant edge is absorbed by that grant.
      pend    <= (pend | req) & ~(load ? sel_onehot : 4'b0000);
      if (load) begin
        half_cnt   <= half_of(sel) - 16'd1;
        presc      <= '0;
        dur_cnt    <= dur_of(sel);
        tone       <= 1'b0;
        grant      <= sel_onehot;
        active_src <= sel;
      end else if (finish) begin
        tone  <= 1'b0;
        presc <= '0;
      end else if (state == PLAY) begin
        if (half_cnt == 16'd0) begin
          half_cnt <= half_of(active_src) - 16'd1;
          tone     <= ~tone;
        end else begin
          half_cnt <= half_cnt - 16'd1;
        end
        if (tick_wrap) begin
          presc   <= '0;
          dur_cnt <= dur_cnt - 8'd1;
        end else begin
          presc <= presc + 18'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sound_arbiter.sv
`timescale 1ns/1ps
module tb_sound_arbiter;

  localparam int TD = 10;
  localparam int HALFS [4] = '{5, 4, 3, 2};
  localparam int DURS  [4] = '{6, 4, 3, 2};

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic       enable;
  logic       speaker;
  logic       busy;
  logic [1:0] active_src;
  logic [3:0] grant;

  sound_arbiter #(
    .TICK_DIV(TD),
    .HALF0(5), .HALF1(4), .HALF2(3), .HALF3(2),
    .DUR0(6),  .DUR1(4),  .DUR2(3),  .DUR3(2)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .enable(enable),
    .speaker(speaker), .busy(busy), .active_src(active_src), .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       spk;
    logic [1:0] act;
    logic [3:0] grant;
  } exp_t;

  exp_t eq[$];
  int   gq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model: play episode described by source and elapsed cycles.
  bit         m_play;
  int         m_src;
  int         m_t;
  logic [3:0] m_pend;
  logic [1:0] m_act;

  task automatic check(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (eq.size() > 0) begin
      e = eq.pop_front();
      check("busy",       busy,       e.busy);
      check("speaker",    speaker,    e.spk);
      check("active_src", active_src, e.act);
      check("grant",      grant,      e.grant);
    end
    if (grant != 4'b0000) begin
      if (gq.size() == 0) begin
        check("unexpected_grant", grant, 0);
      end else begin
        int s;
        s = gq.pop_front();
        check("grant_src", grant, 1 << s);
      end
    end
  end

  task automatic model_init();
    exp_t e;
    m_play = 0; m_src = 0; m_t = 0; m_pend = '0; m_act = '0;
    e = '0;
    eq.push_back(e);
  endtask

  // Apply inputs for one cycle, predict the next cycle, advance the clock.
  task automatic step(input logic [3:0] r, input logic en);
    exp_t       e;
    int         g;
    int         low;
    logic       cur_tone;
    logic [3:0] clr;
    req = r;
    enable = en;
    cur_tone = m_play ? (((m_t / HALFS[m_src]) % 2) == 1) : 1'b0;
    low = 4;
    for (int i = 3; i >= 0; i--) if (m_pend[i]) low = i;
    g = -1;
    clr = '0;
    if (!m_play) begin
      if (low < 4) g = low;
    end else if (low <= m_src) begin
      g = low;
    end
    if (g >= 0) begin
      m_play = 1; m_src = g; m_t = 0; m_act = 2'(g);
      clr = 4'(1 << g);
      gq.push_back(g);
    end else if (m_play) begin
      if (m_t == DURS[m_src] * TD - 1) m_play = 0;
      else m_t++;
    end
    m_pend = (m_pend | r) & ~clr;
    e.busy  = m_play;
    e.spk   = cur_tone & en;
    e.act   = m_act;
    e.grant = (g >= 0) ? 4'(1 << g) : 4'b0000;
    eq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic en);
    for (int i = 0; i < n; i++) step(4'b0000, en);
  endtask

  task automatic do_reset();
    eq.delete();
    gq.delete();
    req = '0;
    reset = 1'b1;
    #2;
    check("rst_busy",    busy,       0);
    check("rst_speaker", speaker,    0);
    check("rst_grant",   grant,      0);
    check("rst_active",  active_src, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_init();
  endtask

  initial begin
    reset = 1'b1;
    req = '0;
    enable = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // Single laser
    step(4'b0100, 1'b1); idle(40, 1'b1);
    // Simultaneous requests: 1 then 3
    step(4'b1010, 1'b1); idle(100, 1'b1);
    // Preemption of source 3 by source 0
    step(4'b1000, 1'b1); idle(6, 1'b1); step(4'b0001, 1'b1); idle(75, 1'b1);
    // Lower priority while busy
    step(4'b0001, 1'b1); idle(10, 1'b1); step(4'b0100, 1'b1); idle(100, 1'b1);
    // Retrigger while muted
    step(4'b0010, 1'b0); idle(15, 1'b0); step(4'b0010, 1'b0); idle(60, 1'b0);
    // Reset mid-play with a lower-priority request pending
    step(4'b0001, 1'b1); idle(5, 1'b1); step(4'b1000, 1'b1); idle(10, 1'b1);
    do_reset();
    idle(30, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] r;
      for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 59) == 0);
      step(r, $urandom_range(0, 7) != 0);
    end
    idle(120, 1'b1);

    @(negedge clk);
    #1;
    check("grants_left", gq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sound_arbiter.md
# sound_arbiter

Shares the single `speaker` pin among four game sound sources: ship death, alien hit, laser shot and menu click. Each source raises a one-cycle request strobe. The arbiter latches pending requests and grants the speaker to the highest-priority one. It then plays that source's square-wave tone for a fixed duration. It sits between the game/ship/alien units and the top-level `speaker` output.

## Interface
- `TICK_DIV`, 250000: clk cycles per duration tick; 10 ms at 25 MHz. Must be at least 2 and fit in 18 bits.
- `HALF0`, 50000: half-period in clk cycles for source 0, ship death (250 Hz). 16 bits, at least 1.
- `HALF1`, 25000: half-period for source 1, alien hit.
- `HALF2`, 12500: half-period for source 2, laser.
- `HALF3`, 6250: half-period for source 3, menu click.
- `DUR0`, 50: duration of source 0 in ticks. 8 bits, at least 1.
- `DUR1`, 20: duration of source 1 in ticks.
- `DUR2`, 8: duration of source 2 in ticks.
- `DUR3`, 5: duration of source 3 in ticks.
- `clk` input 1: system/pixel clock.
- `reset` input 1: asynchronous, active-high.
- `req` input 4: one-cycle request strobes. Bit 0 has the highest priority.
- `enable` input 1: 0 mutes the speaker; sequencing continues unaffected.
- `speaker` output 1: square-wave tone.
- `busy` output 1: high while in PLAY.
- `active_src` output 2: index of the source currently playing. Holds its last value when idle.
- `grant` output 4: one-hot, high for exactly one cycle when a source starts (or restarts) playing.

## Operation
- Pending latch: `pend[i]` is set on any edge where `req[i]`=1. It is cleared on the edge that grants source i.
  - Multiple strobes from the same source before its grant coalesce into one pending request.
  - A set and a clear on the same edge resolves to set only when the strobe arrives after the grant edge; the grant edge itself clears the bit.
- States: IDLE and PLAY.
- IDLE:
  - `speaker`=0 and `busy`=0.
  - If `pend` is nonzero, go to PLAY with source s = lowest set index. On that edge:
    - clear `pend[s]`;
    - load half-period counter with `HALF_s`-1, prescaler with 0, duration counter with `DUR_s`;
    - set the internal tone register to 0;
    - register `grant`=onehot(s) and `active_src`=s.
- PLAY, each cycle:
  - Half-period counter decrements. On reaching 0 it reloads `HALF_s`-1 and the tone register toggles.
  - Prescaler counts 0 to `TICK_DIV`-1 and wraps. At the wrap, the duration counter decrements.
- End of play: when the duration counter would go from 1 to 0, go to IDLE and set tone to 0. PLAY therefore lasts exactly `DUR_s`×`TICK_DIV` cycles.
- Preemption: in PLAY, if `pend` has a bit set at an index ≤ current s, the next edge reloads for the lowest such index exactly as from IDLE.
  - Equal index means retrigger, which restarts the duration.
  - Preemption takes precedence over end-of-play on the same edge.
  - Lower-priority pending bits (index > s) stay latched and are served after.
- `speaker` = tone register AND `enable`, registered.
- Back-to-back: after end-of-play, at least one IDLE cycle always occurs before the next grant. No IDLE cycle occurs on preemption.
- Reset (asynchronous, at any time, including mid-PLAY):
  - state goes to IDLE;
  - `pend`, all counters, the tone register, `speaker`, `busy`, `grant` and `active_src` go to 0.

## Timing
- `req` strobe at cycle 0 sets `pend` at edge 1.
  - From IDLE: PLAY is entered at edge 2, with `grant` and `busy` high in cycle 2.
  - The first `speaker` rise (with `enable`=1) occurs `HALF_s`+1 cycles after the grant edge, because `speaker` is registered.
- Tone period is 2×`HALF_s` cycles at a 50% duty cycle.
- `busy` falls on the edge that ends PLAY. `speaker` is 0 from one cycle later.
- `grant` is never high for two consecutive cycles unless a preemption or retrigger happens exactly then.

## Test plan
All scenarios use `TICK_DIV`=10, `HALF0..3`=5/4/3/2 and `DUR0..3`=6/4/3/2.
- Single laser: `req`=4'b0100 at cycle 0.
  - `grant`=4'b0100 in cycle 2.
  - `speaker` toggles every 3 cycles.
  - `busy` is high for exactly 30 cycles, then `speaker`=0.
- Simultaneous requests: `req`=4'b1010 in one cycle.
  - Source 1 is granted first and plays for 40 cycles.
  - One IDLE cycle follows.
  - Source 3 is then granted with `active_src`=3.
- Preemption: source 3 is playing; `req[0]` arrives at cycle 5 of play.
  - Source 0 is granted 2 cycles later, with no IDLE gap.
  - Source 0 plays its full 60 cycles.
  - Source 3 is not resumed because it is no longer pending.
- Lower priority while busy: source 0 is playing and `req[2]` arrives.
  - `pend[2]` holds; source 0 is not interrupted.
  - Source 2 is granted one cycle after source 0 ends.
- Retrigger and mute: source 1 is playing with `enable`=0.
  - `speaker` stays 0 while `busy`=1.
  - A repeated `req[1]` restarts the duration, so `busy` lasts 40 cycles after the second grant.
- Reset mid-play: assert `reset` in cycle 15 of a source-0 play.
  - All outputs go to 0 immediately; `pend` is cleared.
  - After release, nothing plays until a new `req` arrives.
